// File: rtl/dram_read_sequencer.sv
// Converts 16-bit-sample address requests into DRAM read commands and returns the
// selected lane of each 128-bit word in request order. Optional word cache: DRAM_READ_CACHE_EN.
module dram_read_sequencer #(
   parameter int unsigned DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_axis_tvalid,
   output logic         req_axis_tready,
   input  logic [23:0]  req_axis_tdata,
   input  logic         req_axis_tlast,
   output logic         app_en,
   output logic [2:0]   app_cmd,
   output logic [23:0]  app_addr,
   input  logic         app_rdy,
   input  logic [127:0] app_rd_data,
   input  logic         app_rd_data_valid,
   output logic         sample_axis_tvalid,
   input  logic         sample_axis_tready,
   output logic [15:0]  sample_axis_tdata,
   output logic         sample_axis_tlast,
   output logic         err_unexpected_rd
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [2:0] CMD_READ = 3'b001;

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e        state_q, state_d;
   logic          app_en_q, app_en_d;
   logic [2:0]    app_cmd_q, app_cmd_d;
   logic [23:0]   app_addr_q, app_addr_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic          err_q, err_d;

   // tag = {lane select, tlast, word address}
   logic [24:0]   tag_mem [DEPTH];
   logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [16:0]   out_mem [DEPTH];
   logic [AW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
   logic [CW-1:0] out_count_q, out_count_d;

   logic          accept, hit, issue, ret, push, pop;
   logic [CW:0]   in_use;
   logic [2:0]    tag_sel;
   logic          tag_last;
   logic [20:0]   tag_word;
   logic [16:0]   push_data;
   logic [16:0]   out_head;
   logic          hit_pend_q;
   logic [16:0]   hit_sample_q;

   assign in_use          = {1'b0, outstanding_q} + {1'b0, out_count_q} + {{CW{1'b0}}, hit_pend_q};
   assign req_axis_tready = !rst && (state_q == IDLE) && (in_use < (CW+1)'(DEPTH));
   assign accept          = req_axis_tvalid && req_axis_tready;
   assign ret             = app_rd_data_valid && (outstanding_q != '0);
   assign {tag_sel, tag_last, tag_word} = tag_mem[tag_rd_q];
   assign pop             = sample_axis_tvalid && sample_axis_tready;

`ifdef DRAM_READ_CACHE_EN
   logic          cache_valid_q, cache_valid_d;
   logic [20:0]   cache_word_q, cache_word_d;
   logic [127:0]  cache_data_q, cache_data_d;
   logic          hit_pend_d;
   logic [16:0]   hit_sample_d;

   // A hit is only safe with nothing outstanding, which keeps samples in order.
   always_comb begin
      hit           = accept && cache_valid_q && (outstanding_q == '0)
                      && (req_axis_tdata[23:3] == cache_word_q);
      hit_pend_d    = hit;
      hit_sample_d  = {req_axis_tlast, cache_data_q[{req_axis_tdata[2:0], 4'b0000} +: 16]};
      cache_valid_d = cache_valid_q;
      cache_word_d  = cache_word_q;
      cache_data_d  = cache_data_q;
      if (ret) begin
         cache_valid_d = 1'b1;
         cache_word_d  = tag_word;
         cache_data_d  = app_rd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_valid_q <= 1'b0;
         cache_word_q  <= '0;
         cache_data_q  <= '0;
         hit_pend_q    <= 1'b0;
         hit_sample_q  <= '0;
      end else begin
         cache_valid_q <= cache_valid_d;
         cache_word_q  <= cache_word_d;
         cache_data_q  <= cache_data_d;
         hit_pend_q    <= hit_pend_d;
         hit_sample_q  <= hit_sample_d;
      end
   end
`else
   logic unused_tag_word;
   assign hit             = 1'b0;
   assign hit_pend_q      = 1'b0;
   assign hit_sample_q    = '0;
   assign unused_tag_word = ^tag_word;
`endif

   always_comb begin
      issue         = accept && !hit;
      state_d       = state_q;
      app_addr_d    = app_addr_q;
      outstanding_d = outstanding_q;
      err_d         = err_q | (app_rd_data_valid && (outstanding_q == '0));
      tag_wr_d      = tag_wr_q;
      tag_rd_d      = tag_rd_q;
      out_wr_d      = out_wr_q;
      out_rd_d      = out_rd_q;
      out_count_d   = out_count_q;

      if (state_q == IDLE) begin
         if (issue) begin
            state_d    = ISSUE;
            app_addr_d = {req_axis_tdata[23:3], 3'b000};
         end
      end else if (app_rdy) begin
         state_d = IDLE;
      end
      app_en_d  = (state_d == ISSUE);
      app_cmd_d = (state_d == ISSUE) ? CMD_READ : 3'b000;

      if (issue) tag_wr_d = tag_wr_q + AW'(1);
      if (ret)   tag_rd_d = tag_rd_q + AW'(1);
      if (issue && !ret)      outstanding_d = outstanding_q + CW'(1);
      else if (!issue && ret) outstanding_d = outstanding_q - CW'(1);

      push      = ret || hit_pend_q;
      push_data = ret ? {tag_last, app_rd_data[{tag_sel, 4'b0000} +: 16]} : hit_sample_q;
      if (push) out_wr_d = out_wr_q + AW'(1);
      if (pop)  out_rd_d = out_rd_q + AW'(1);
      if (push && !pop)      out_count_d = out_count_q + CW'(1);
      else if (!push && pop) out_count_d = out_count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         app_en_q      <= 1'b0;
         app_cmd_q     <= '0;
         app_addr_q    <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         tag_wr_q      <= '0;
         tag_rd_q      <= '0;
         out_wr_q      <= '0;
         out_rd_q      <= '0;
         out_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         app_en_q      <= app_en_d;
         app_cmd_q     <= app_cmd_d;
         app_addr_q    <= app_addr_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         tag_wr_q      <= tag_wr_d;
         tag_rd_q      <= tag_rd_d;
         out_wr_q      <= out_wr_d;
         out_rd_q      <= out_rd_d;
         out_count_q   <= out_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (issue) tag_mem[tag_wr_q] <= {req_axis_tdata[2:0], req_axis_tlast, req_axis_tdata[23:3]};
      if (push)  out_mem[out_wr_q] <= push_data;
   end

   assign out_head           = out_mem[out_rd_q];
   assign sample_axis_tvalid = (out_count_q != '0);
   assign sample_axis_tdata  = sample_axis_tvalid ? out_head[15:0] : '0;
   assign sample_axis_tlast  = sample_axis_tvalid && out_head[16];
   assign app_en             = app_en_q;
   assign app_cmd            = app_cmd_q;
   assign app_addr           = app_addr_q;
   assign err_unexpected_rd  = err_q;
endmodule

// File: tb/tb_dram_read_sequencer.sv
// Randomized bench for dram_read_sequencer: a DRAM controller model returns words whose lanes
// are a fixed function of address; expected samples come from the request stream alone.
module tb_dram_read_sequencer;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req_axis_tvalid = 1'b0;
   logic         req_axis_tready;
   logic [23:0]  req_axis_tdata = '0;
   logic         req_axis_tlast = 1'b0;
   logic         app_en;
   logic [2:0]   app_cmd;
   logic [23:0]  app_addr;
   logic         app_rdy = 1'b0;
   logic [127:0] app_rd_data = '0;
   logic         app_rd_data_valid = 1'b0;
   logic         sample_axis_tvalid;
   logic         sample_axis_tready = 1'b0;
   logic [15:0]  sample_axis_tdata;
   logic         sample_axis_tlast;
   logic         err_unexpected_rd;

   always #5 clk = ~clk;

   dram_read_sequencer #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .req_axis_tvalid(req_axis_tvalid), .req_axis_tready(req_axis_tready),
      .req_axis_tdata(req_axis_tdata), .req_axis_tlast(req_axis_tlast),
      .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .sample_axis_tvalid(sample_axis_tvalid), .sample_axis_tready(sample_axis_tready),
      .sample_axis_tdata(sample_axis_tdata), .sample_axis_tlast(sample_axis_tlast),
      .err_unexpected_rd(err_unexpected_rd)
   );

   typedef struct {int unsigned due; logic [20:0] word;} ret_t;

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned cyc = 0;
   ret_t        ctl_q[$];
   logic [16:0] got_q[$];
   logic [16:0] exp_q[$];
   logic [20:0] cmd_q[$];
   logic [20:0] reqw_q[$];
   bit          req_taken = 1'b0;
   bit          rdy_rand = 1'b0;
   bit          smp_rand = 1'b0;
   bit          auto_ret = 1'b0;
   bit          lane_mode = 1'b0;
   int unsigned lat_max = 0;
   int unsigned inj_ret = 0;

   function automatic logic [15:0] lane_val(input logic [20:0] word, input logic [2:0] k);
      logic [31:0] v;
      if (lane_mode) return 16'h1110 + {13'd0, k};
      v = ({11'd0, word} * 32'd8 + {29'd0, k}) * 32'd40503;
      return v[15:0] ^ v[31:16];
   endfunction

   function automatic logic [127:0] make_word(input logic [20:0] word);
      logic [127:0] w;
      for (int unsigned k = 0; k < 8; k++) w[16*k +: 16] = lane_val(word, 3'(k));
      return w;
   endfunction

   // one clock: observe handshakes at negedge, then drive the controller side after the edge
   task automatic step();
      ret_t r;
      @(negedge clk);
      req_taken = req_axis_tvalid && req_axis_tready;
      if (req_taken) begin
         exp_q.push_back({req_axis_tlast, lane_val(req_axis_tdata[23:3], req_axis_tdata[2:0])});
         reqw_q.push_back(req_axis_tdata[23:3]);
      end
      if (app_en && app_rdy) begin
         cmd_q.push_back(app_addr[23:3]);
         ctl_q.push_back('{due: cyc + 1 + $urandom_range(lat_max, 0), word: app_addr[23:3]});
      end
      if (sample_axis_tvalid && sample_axis_tready) got_q.push_back({sample_axis_tlast, sample_axis_tdata});
      @(posedge clk);
      #1;
      cyc++;
      app_rd_data_valid = 1'b0;
      if (inj_ret > 0) begin
         inj_ret--;
         app_rd_data_valid = 1'b1;
         app_rd_data = {8{16'hDEAD}};
      end else if (auto_ret && ctl_q.size() > 0 && ctl_q[0].due <= cyc) begin
         r = ctl_q.pop_front();
         app_rd_data_valid = 1'b1;
         app_rd_data = make_word(r.word);
      end
      if (rdy_rand) app_rdy = ($urandom_range(3, 0) != 0);
      if (smp_rand) sample_axis_tready = ($urandom_range(1, 0) != 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_axis_tvalid = 1'b0;
      app_rd_data_valid = 1'b0;
      inj_ret = 0;
      rdy_rand = 1'b0;
      smp_rand = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ctl_q.delete(); got_q.delete(); exp_q.delete(); cmd_q.delete(); reqw_q.delete();
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      n_vec++; if (req_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b want 0", req_axis_tready); end
      n_vec++; if (app_en !== 1'b0) begin n_err++; $display("FAIL rst_app_en: got %b want 0", app_en); end
      n_vec++; if (app_cmd !== 3'b000) begin n_err++; $display("FAIL rst_app_cmd: got %h want 0", app_cmd); end
      n_vec++; if (app_addr !== 24'h0) begin n_err++; $display("FAIL rst_app_addr: got %h want 0", app_addr); end
      n_vec++; if ({sample_axis_tvalid, sample_axis_tlast, sample_axis_tdata} !== 18'h0) begin
         n_err++; $display("FAIL rst_sample: got %b/%b/%h want 0", sample_axis_tvalid, sample_axis_tlast, sample_axis_tdata); end
      n_vec++; if (err_unexpected_rd !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_unexpected_rd); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      n_vec++; if (req_axis_tready !== 1'b1) begin n_err++; $display("FAIL post_rst_tready: got %b want 1", req_axis_tready); end
   endtask

   task automatic test_basic();
      logic [16:0] obs;
      int unsigned k;
      do_reset();
      lane_mode = 1'b1; auto_ret = 1'b1; lat_max = 0; app_rdy = 1'b1; sample_axis_tready = 1'b1;
      req_axis_tdata = 24'h000013; req_axis_tlast = 1'b1; req_axis_tvalid = 1'b1;
      k = 0;
      do begin step(); k++; if (req_taken) req_axis_tvalid = 1'b0; end while (got_q.size() == 0 && k < 50);
      n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL basic_count: got %0d samples want 1", got_q.size()); end
      obs = (got_q.size() > 0) ? got_q[0] : 17'h0;
      n_vec++; if (obs !== {1'b1, 16'h1113}) begin n_err++; $display("FAIL basic_sample: got %h want %h", obs, {1'b1, 16'h1113}); end
      n_vec++; if (cmd_q.size() != 1 || cmd_q[0] !== 21'h2) begin n_err++; $display("FAIL basic_cmd: got %0d cmds want 1 at word 2", cmd_q.size()); end
      lane_mode = 1'b0;
   endtask

   task automatic test_rdy_stall();
      int unsigned k;
      logic [16:0] obs;
      do_reset();
      app_rdy = 1'b0; auto_ret = 1'b1; lat_max = 0; sample_axis_tready = 1'b1;
      req_axis_tdata = 24'hABCDE5; req_axis_tlast = 1'b0; req_axis_tvalid = 1'b1;
      k = 0;
      do begin step(); k++; end while (!req_taken && k < 10);
      req_axis_tvalid = 1'b0;
      n_vec++; if (!req_taken) begin n_err++; $display("FAIL stall_accept: got no handshake want one"); end
      for (int unsigned i = 0; i < 5; i++) begin
         n_vec++; if ({app_en, app_cmd, app_addr, req_axis_tready} !== {1'b1, 3'b001, 24'hABCDE0, 1'b0}) begin
            n_err++; $display("FAIL stall_cycle%0d: got en=%b cmd=%h addr=%h tready=%b want 1/1/abcde0/0",
                              i, app_en, app_cmd, app_addr, req_axis_tready); end
         step();
      end
      app_rdy = 1'b1;
      k = 0;
      do begin step(); k++; end while (got_q.size() == 0 && k < 30);
      obs = (got_q.size() > 0) ? got_q[0] : 17'h0;
      n_vec++; if (obs !== exp_q[0]) begin n_err++; $display("FAIL stall_sample: got %h want %h", obs, exp_q[0]); end
      n_vec++; if (cmd_q.size() != 1) begin n_err++; $display("FAIL stall_cmds: got %0d want 1", cmd_q.size()); end
   endtask

   task automatic test_credit();
      int unsigned sent = 0;
      int unsigned k;
      do_reset();
      app_rdy = 1'b1; auto_ret = 1'b1; lat_max = 3; sample_axis_tready = 1'b0;
      req_axis_tdata = 24'($urandom); req_axis_tlast = 1'($urandom); req_axis_tvalid = 1'b1;
      for (int unsigned i = 0; i < 80; i++) begin
         step();
         if (req_taken) begin sent++; req_axis_tdata = 24'($urandom); req_axis_tlast = 1'($urandom); end
      end
      n_vec++; if (sent != 8) begin n_err++; $display("FAIL credit_accepted: got %0d want 8", sent); end
      n_vec++; if (req_axis_tready !== 1'b0) begin n_err++; $display("FAIL credit_stall: got tready %b want 0", req_axis_tready); end
      n_vec++; if (sample_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL credit_tvalid: got %b want 1", sample_axis_tvalid); end
      sample_axis_tready = 1'b1;
      step();
      sample_axis_tready = 1'b0;
      k = 0;
      do begin step(); k++; end while (!req_taken && k < 10);
      req_axis_tvalid = 1'b0;
      n_vec++; if (!req_taken) begin n_err++; $display("FAIL credit_reenable: got no 9th handshake want one"); end
      sample_axis_tready = 1'b1;
      k = 0;
      while (got_q.size() < 9 && k < 100) begin step(); k++; end
      n_vec++; if (got_q.size() != 9) begin n_err++; $display("FAIL credit_drain: got %0d samples want 9", got_q.size()); end
      for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL credit_sample%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_unexpected();
      int unsigned k;
      do_reset();
      app_rdy = 1'b1; auto_ret = 1'b1; lat_max = 2; sample_axis_tready = 1'b1;
      n_vec++; if (err_unexpected_rd !== 1'b0) begin n_err++; $display("FAIL unexp_before: got %b want 0", err_unexpected_rd); end
      inj_ret = 1;
      step(); step();
      n_vec++; if (err_unexpected_rd !== 1'b1) begin n_err++; $display("FAIL unexp_set: got %b want 1", err_unexpected_rd); end
      req_axis_tdata = 24'($urandom); req_axis_tlast = 1'b1; req_axis_tvalid = 1'b1;
      k = 0;
      do begin step(); k++; if (req_taken) req_axis_tvalid = 1'b0; end while (got_q.size() == 0 && k < 40);
      repeat (10) step();
      n_vec++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL unexp_followup: got %0d samples want 1 matching", got_q.size()); end
      n_vec++; if (err_unexpected_rd !== 1'b1) begin n_err++; $display("FAIL unexp_sticky: got %b want 1", err_unexpected_rd); end
   endtask

   task automatic test_reset_inflight();
      int unsigned k;
      do_reset();
      app_rdy = 1'b1; auto_ret = 1'b0; sample_axis_tready = 1'b1;
      for (int unsigned n = 0; n < 3; n++) begin
         req_axis_tdata = 24'($urandom) | 24'h000808; req_axis_tlast = 1'b0; req_axis_tvalid = 1'b1;
         k = 0;
         do begin step(); k++; end while (!req_taken && k < 20);
         req_axis_tvalid = 1'b0;
         if (n == 2) app_rdy = 1'b0;
      end
      step();
      n_vec++; if (app_en !== 1'b1 || cmd_q.size() != 2) begin
         n_err++; $display("FAIL inflight_setup: got en=%b cmds=%0d want 1/2", app_en, cmd_q.size()); end
      rst = 1'b1;
      #1;
      n_vec++; if ({req_axis_tready, app_en, app_cmd, app_addr} !== 29'h0) begin
         n_err++; $display("FAIL inflight_rst_cmd: got tready=%b en=%b cmd=%h addr=%h want 0", req_axis_tready, app_en, app_cmd, app_addr); end
      n_vec++; if ({sample_axis_tvalid, sample_axis_tlast, sample_axis_tdata, err_unexpected_rd} !== 19'h0) begin
         n_err++; $display("FAIL inflight_rst_out: got %b/%b/%h/%b want 0", sample_axis_tvalid, sample_axis_tlast, sample_axis_tdata, err_unexpected_rd); end
      do_reset();
      app_rdy = 1'b1; auto_ret = 1'b1;
      inj_ret = 3;
      repeat (15) step();
      n_vec++; if (got_q.size() != 0 || sample_axis_tvalid !== 1'b0) begin
         n_err++; $display("FAIL inflight_late: got %0d samples tvalid=%b want 0/0", got_q.size(), sample_axis_tvalid); end
      n_vec++; if (err_unexpected_rd !== 1'b1) begin n_err++; $display("FAIL inflight_err: got %b want 1", err_unexpected_rd); end
      n_vec++; if (cmd_q.size() != 0) begin n_err++; $display("FAIL inflight_cmds: got %0d want 0", cmd_q.size()); end
   endtask

   task automatic test_random();
      int unsigned total = 150;
      int unsigned sent = 0;
      int unsigned k = 0;
      int unsigned max_if = 0;
      logic [20:0] last_w = '0;
      do_reset();
      rdy_rand = 1'b1; smp_rand = 1'b1; auto_ret = 1'b1; lat_max = 6;
      while (sent < total && k < 20000) begin
         if (!req_axis_tvalid && $urandom_range(2, 0) != 0) begin
            if (sent > 0 && $urandom_range(3, 0) == 0) req_axis_tdata = {last_w, 3'($urandom)};
            else req_axis_tdata = 24'($urandom);
            req_axis_tlast = ($urandom_range(4, 0) == 0);
            req_axis_tvalid = 1'b1;
         end
         step();
         k++;
         if (req_taken) begin sent++; last_w = req_axis_tdata[23:3]; req_axis_tvalid = 1'b0; end
         if (sent - got_q.size() > max_if) max_if = sent - got_q.size();
      end
      smp_rand = 1'b0; sample_axis_tready = 1'b1;
      k = 0;
      while (got_q.size() < total && k < 2000) begin step(); k++; end
      n_vec++; if (got_q.size() != total) begin n_err++; $display("FAIL rand_count: got %0d samples want %0d", got_q.size(), total); end
      n_vec++; if (max_if > 8) begin n_err++; $display("FAIL rand_inflight: got %0d want <= 8", max_if); end
      for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_sample%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
`ifndef DRAM_READ_CACHE_EN
      n_vec++; if (cmd_q.size() != total) begin n_err++; $display("FAIL rand_cmds: got %0d want %0d", cmd_q.size(), total); end
      for (int unsigned i = 0; i < cmd_q.size() && i < reqw_q.size(); i++) begin
         n_vec++; if (cmd_q[i] !== reqw_q[i]) begin n_err++; $display("FAIL rand_cmd%0d: got %h want %h", i, cmd_q[i], reqw_q[i]); end
      end
`endif
      n_vec++; if (err_unexpected_rd !== 1'b0) begin n_err++; $display("FAIL rand_err: got %b want 0", err_unexpected_rd); end
   endtask

`ifdef DRAM_READ_CACHE_EN
   task automatic test_cache();
      int unsigned k;
      logic [33:0] obs;
      do_reset();
      app_rdy = 1'b1; auto_ret = 1'b1; lat_max = 2; sample_axis_tready = 1'b1;
      req_axis_tdata = 24'h000020; req_axis_tlast = 1'b0; req_axis_tvalid = 1'b1;
      k = 0;
      do begin step(); k++; if (req_taken) req_axis_tvalid = 1'b0; end while (got_q.size() < 1 && k < 40);
      req_axis_tdata = 24'h000025; req_axis_tlast = 1'b1; req_axis_tvalid = 1'b1;
      k = 0;
      do begin step(); k++; if (req_taken) req_axis_tvalid = 1'b0; end while (got_q.size() < 2 && k < 40);
      n_vec++; if (cmd_q.size() != 1) begin n_err++; $display("FAIL cache_cmds: got %0d want 1", cmd_q.size()); end
      obs = (got_q.size() == 2) ? {got_q[0], got_q[1]} : 34'h0;
      n_vec++; if (obs !== {1'b0, lane_val(21'h4, 3'd0), 1'b1, lane_val(21'h4, 3'd5)}) begin
         n_err++; $display("FAIL cache_samples: got %h want %h", obs, {1'b0, lane_val(21'h4, 3'd0), 1'b1, lane_val(21'h4, 3'd5)}); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_rdy_stall();
      test_credit();
      test_unexpected();
      test_reset_inflight();
      test_random();
`ifdef DRAM_READ_CACHE_EN
      test_cache();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
